// File: rtl/store_merge_unit.sv
// Store sequencer: word stores write directly, half/byte stores read-modify-write the target word.
// Optional macro STORE_MERGE_ALIGN_CHECK_EN adds misaligned half/word detection and the align_err port.
module store_merge_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done
`ifdef STORE_MERGE_ALIGN_CHECK_EN
    ,
    output logic        align_err
`endif
);

    localparam int DATA_W = 32;
    localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t              state, state_next;
    logic [1:0]          req_size_p0, req_size_next;
    logic [DATA_W-1:0]   req_wdata_p0, req_wdata_next;
    logic [2:0]          cnt_p0, cnt_next;
    logic [DATA_W-1:0]   mem_addr_next, mem_wdata_next;
    logic                mem_wr_next;
    logic                align_next;
    logic                align_q;

    // size bit 1 has priority, so 2'b11 merges as a byte
    function automatic logic [DATA_W-1:0] merge_word(input logic [1:0] sz,
                                                     input logic [DATA_W-1:0] rd,
                                                     input logic [DATA_W-1:0] wd);
        if (sz[1])
            return {rd[31:8], wd[7:0]};
        else if (sz[0])
            return {rd[31:16], wd[15:0]};
        else
            return wd;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
        if (sz[1])
            return 1'b0;
        else if (sz[0])
            return a_lo[0];
        else
            return |a_lo;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_size_p0  <= '0;
            req_wdata_p0 <= '0;
            cnt_p0       <= '0;
            mem_addr     <= '0;
            mem_wr       <= 1'b0;
            mem_wdata    <= '0;
            align_q      <= 1'b0;
        end else begin
            state        <= state_next;
            req_size_p0  <= req_size_next;
            req_wdata_p0 <= req_wdata_next;
            cnt_p0       <= cnt_next;
            mem_addr     <= mem_addr_next;
            mem_wr       <= mem_wr_next;
            mem_wdata    <= mem_wdata_next;
            align_q      <= align_next;
        end
    end

    // Memory-facing outputs are computed for the next state and registered at the transition
    always_comb begin
        state_next     = state;
        req_size_next  = req_size_p0;
        req_wdata_next = req_wdata_p0;
        cnt_next       = cnt_p0;
        mem_addr_next  = mem_addr;
        mem_wr_next    = 1'b0;
        mem_wdata_next = mem_wdata;
        align_next     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    req_size_next  = size;
                    req_wdata_next = wdata;
`ifdef STORE_MERGE_ALIGN_CHECK_EN
                    if (misaligned(size, addr[1:0])) begin
                        align_next = 1'b1;
                        state_next = DONE;
                    end else
`endif
                    begin
                        mem_addr_next = addr;
                        if (size == 2'b00) begin
                            mem_wr_next    = 1'b1;
                            mem_wdata_next = wdata;
                            state_next     = WRITE;
                        end else begin
                            state_next = READ;
                        end
                    end
                end
            end
            READ: begin
                cnt_next   = WAIT_INIT;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_p0 == 3'd0) begin
                    mem_wdata_next = merge_word(req_size_p0, mem_rdata, req_wdata_p0);
                    mem_wr_next    = 1'b1;
                    state_next     = WRITE;
                end else begin
                    cnt_next = cnt_p0 - 3'd1;
                end
            end
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef STORE_MERGE_ALIGN_CHECK_EN
    assign align_err = align_q;
`else
    logic unused_align;
    assign unused_align = align_q ^ (^misaligned(size, addr[1:0]));
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: two instances (latency 1 and 3) with latency-piped memory models.
module tb_store_merge_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, sel;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        start1, start3;
    logic [31:0] rdata1, rdata3, mem_addr1, mem_addr3, mem_wdata1, mem_wdata3;
    logic        mem_wr1, mem_wr3, busy1, busy3, done1, done3;
    logic        align1, align3;

    assign start1 = start & ~sel;
    assign start3 = start & sel;

    store_merge_unit #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .size(size), .addr(addr), .wdata(wdata),
        .mem_rdata(rdata1), .mem_addr(mem_addr1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1),
        .busy(busy1), .done(done1)
`ifdef STORE_MERGE_ALIGN_CHECK_EN
        , .align_err(align1)
`endif
    );

    store_merge_unit #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .size(size), .addr(addr), .wdata(wdata),
        .mem_rdata(rdata3), .mem_addr(mem_addr3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3),
        .busy(busy3), .done(done3)
`ifdef STORE_MERGE_ALIGN_CHECK_EN
        , .align_err(align3)
`endif
    );

`ifndef STORE_MERGE_ALIGN_CHECK_EN
    assign align1 = 1'b0;
    assign align3 = 1'b0;
`endif

    logic [31:0] o_addr, o_wdata;
    logic        o_wr, o_busy, o_done, o_align;
    assign o_addr  = sel ? mem_addr3  : mem_addr1;
    assign o_wdata = sel ? mem_wdata3 : mem_wdata1;
    assign o_wr    = sel ? mem_wr3    : mem_wr1;
    assign o_busy  = sel ? busy3      : busy1;
    assign o_done  = sel ? done3      : done1;
    assign o_align = sel ? align3     : align1;

    // Memory returns the stored word only for the target address; anything else reads as filler
    logic [31:0] mem_tgt, mem_word;
    logic [31:0] p3 [3];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return (a === mem_tgt) ? mem_word : 32'hA5A5_A5A5;
    endfunction

    always @(posedge clk) begin
        rdata1 <= mem_read(mem_addr1);
        p3[0]  <= mem_read(mem_addr3);
        p3[1]  <= p3[0];
        p3[2]  <= p3[1];
    end
    assign rdata3 = p3[2];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  tests = 0;
    int  fails = 0;
    int  wr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wr1 === 1'b1 || mem_wr3 === 1'b1) begin
            wr_cnt++;
            chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", o_addr, e.a);
                chk("wr_data", o_wdata, e.d);
            end
        end
    end

    task automatic store(input bit s, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mw, input logic [31:0] ex,
                         input int lat, input int nwr, input bit aerr, input bit interfere,
                         input string tag);
        bit found;
        found    = 1'b0;
        mem_tgt  = a;
        mem_word = mw;
        if (nwr > 0) exp_q.push_back('{a: a, d: ex});
        @(negedge clk);
        sel = s; start = 1'b1; size = sz; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        start = 1'b0; size = ~sz; addr = 32'hFFFF_FFF0; wdata = ~wd;
        wr_cnt = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(negedge clk);
            if (interfere) begin
                start = (k <= 2);
                wdata = 32'hCAFE_0000 + 32'(k);
            end
            if (o_done === 1'b1) begin
                found = 1'b1;
                chk({tag, "_latency"}, 32'(k), 32'(lat));
                chk({tag, "_align_err"}, {31'b0, o_align}, {31'b0, aerr});
            end else begin
                chk({tag, "_busy"}, {31'b0, o_busy}, 32'd1);
            end
        end
        start = 1'b0;
        if (!found) begin
            chk({tag, "_done_timeout"}, 32'd0, 32'd1);
            exp_q.delete();
        end
        chk({tag, "_writes"}, 32'(wr_cnt), 32'(nwr));
        @(negedge clk);
        chk({tag, "_idle_after"}, {30'b0, o_busy, o_done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sel = 1'b0; size = 2'b00; addr = '0; wdata = '0;
        mem_tgt = '0; mem_word = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_addr", mem_addr1, 32'd0);
        chk("rst_mem_wdata", mem_wdata1, 32'd0);
        chk("rst_ctrl", {28'b0, mem_wr1, busy1, done1, align1}, 32'd0);
        chk("rst_ctrl3", {28'b0, mem_wr3, busy3, done3, align3}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        store(1'b0, 2'b00, 32'h40, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 2, 1, 1'b0, 1'b0, "word");
        store(1'b0, 2'b01, 32'h44, 32'h1234_ABCD, 32'h5566_7788, 32'h5566_ABCD, 4, 1, 1'b0, 1'b0, "half");
        store(1'b0, 2'b10, 32'h48, 32'hFFFF_FF77, 32'hAABB_CCDD, 32'hAABB_CC77, 4, 1, 1'b0, 1'b0, "byte");
        store(1'b1, 2'b11, 32'h80, 32'h0000_00FE, 32'h1122_3344, 32'h1122_33FE, 6, 1, 1'b0, 1'b0, "byte_l3");
        store(1'b0, 2'b01, 32'h4C, 32'h0000_BEEF, 32'h1111_2222, 32'h1111_BEEF, 4, 1, 1'b0, 1'b1, "ignore_start");

        // Abandon a half store in WAIT; nothing may be written afterwards
        sel = 1'b0; mem_tgt = 32'h50; mem_word = 32'h9988_7766;
        @(negedge clk);
        start = 1'b1; size = 2'b01; addr = 32'h50; wdata = 32'h1111_2222;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", {31'b0, busy1}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_mem_addr", mem_addr1, 32'd0);
        chk("midrst_mem_wdata", mem_wdata1, 32'd0);
        chk("midrst_ctrl", {29'b0, mem_wr1, busy1, done1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", {30'b0, mem_wr1, done1}, 32'd0);
        end
        store(1'b0, 2'b01, 32'h54, 32'h0000_4321, 32'hCAFE_F00D, 32'hCAFE_4321, 4, 1, 1'b0, 1'b0, "after_reset");

`ifdef STORE_MERGE_ALIGN_CHECK_EN
        store(1'b0, 2'b00, 32'h42, 32'h0BAD_0BAD, 32'h0, 32'h0, 1, 0, 1'b1, 1'b0, "align_word");
        store(1'b0, 2'b01, 32'h45, 32'h0000_1234, 32'h0, 32'h0, 1, 0, 1'b1, 1'b0, "align_half");
        store(1'b0, 2'b10, 32'h43, 32'h0000_0011, 32'h7766_5544, 32'h7766_5511, 4, 1, 1'b0, 1'b0, "align_byte");
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
